work_slave_csr: RTL and testbench
=================================

Name: work_slave_csr

Overview:
- Avalon-MM slave (responder) that the PCIe host uses to load mining work and collect found nonces.
- Holds a shadow copy of midstate, header data and start nonce. On a start command it dispatches a latched copy to the hashing core.
- Buffers the core's found nonces in a small FIFO; the host drains it by reading a register.
- Sits between the Qsys PCIe interconnect and design_core, on the same clk as the read/write masters.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2.
- ADDR_W, 5, word address width of the slave port.

Ports:
- clk  in  1  system clock (soc_clk domain)
- reset  in  1  synchronous, active-high reset
- avs_address  in  ADDR_W  word address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data; full-word writes only, no byteenable
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  read data valid, fixed latency 1
- work_valid  out  1  dispatched work available to core
- work_ready  in  1  core accepts work
- mid_state  out  256  latched midstate
- head_data  out  512  latched header block
- nonce_start  out  32  latched first nonce
- core_abort  out  1  one-cycle pulse to stop core
- res_valid  in  1  core found nonce this cycle
- res_nonce  in  32  found nonce
- res_done  in  1  one-cycle pulse: core exhausted nonce range

Behaviour:
- Reset: all shadow registers 0, latched outputs 0; work_valid, core_abort and avs_readdatavalid 0; avs_readdata 0; FIFO empty; sticky flags 0; state IDLE.
- No waitrequest: every write is accepted in one cycle.
- Reads: avs_readdatavalid asserts exactly 1 cycle after avs_read, with data. Simultaneous read and write to the same address returns the pre-write value.
- Register map (word addresses):
  - 0x00–0x07 MID0..7; MID0 = mid_state[255:224].
  - 0x08–0x17 HEAD0..15; HEAD0 = head_data[511:480].
  - 0x18 NONCE_START, R/W.
  - 0x19 CTRL, write-only, reads 0: bit0 start, bit1 abort, bit2 clear sticky flags.
  - 0x1A STATUS, RO: [1:0] state, [2] fifo_empty, [5:3] fifo_count, [6] overflow, [7] start_err, [8] range_done.
  - 0x1B RESULT, RO with pop side effect.
  - All other addresses read 0; writes to them are ignored.
- Shadow registers are always writable. Writes during RUNNING do not affect mid_state, head_data or nonce_start, which are latched only at dispatch.
- FSM states, STATUS encoding:
  - IDLE 0: start → latch shadows into outputs, go to DISPATCH.
  - DISPATCH 1: work_valid=1. When work_ready=1 in the same cycle → RUNNING, and work_valid drops the next cycle.
  - RUNNING 2: res_done → DONE, set range_done.
  - DONE 3: start → latch and go to DISPATCH; otherwise hold.
- Start in DISPATCH or RUNNING is ignored and sets start_err (sticky).
- Abort in any non-IDLE state: core_abort pulses 1 cycle, go to IDLE, work_valid deasserts next cycle. Abort in IDLE: no pulse.
- Start and abort set together: abort wins.
- Result FIFO:
  - res_valid pushes res_nonce.
  - Push while full drops the new nonce and sets overflow (sticky).
  - Read of RESULT when non-empty returns the head and pops it.
  - Read of RESULT when empty returns 32'hFFFFFFFF and does not pop.
  - Push and pop in the same cycle when non-full: both take effect, count unchanged. When full: pop first, then push accepted, no overflow.
- res_valid in any state is captured, so late results after an abort are kept.
- Sticky flags are cleared only by CTRL bit2 or reset. Clear and set in the same cycle: set wins.

Optional Feature:
- Macro WORK_SLAVE_IRQ_EN.
- Defined:
  - adds output port irq (1 bit) and register 0x1C IRQ_EN (R/W, bit0 result, bit1 range_done).
  - irq = (IRQ_EN[0] & ~fifo_empty) | (IRQ_EN[1] & range_done), registered, 1-cycle latency.
- Undefined: no irq port; 0x1C reads 0.

Decomposition:
- Package work_slave_pkg: state enum (IDLE, DISPATCH, RUNNING, DONE); register address localparams; STATUS bit-position constants; EMPTY_NONCE = 32'hFFFFFFFF.
- Sub-module result_fifo: synchronous FIFO with push, pop, full, empty, count and FIFO_DEPTH parameter.
- FSM, register file and read mux live in work_slave_csr.

Test Plan:
- Load MID0=0x6A09E667, HEAD15=0x00000280, NONCE_START=0x10, write CTRL=1, hold work_ready=0 for 3 cycles then 1 → work_valid high for 4 cycles; mid_state[255:224]=0x6A09E667; nonce_start=0x10; STATUS[1:0]=2.
- Rewrite MID0=0 while RUNNING, then write CTRL=1 → mid_state unchanged; start_err=1; state stays 2.
- Push 5 nonces (0x1..0x5) with FIFO_DEPTH=4 → overflow=1, count=4; four RESULT reads return 1,2,3,4; fifth read returns 0xFFFFFFFF with readdatavalid 1 cycle after each read.
- With FIFO full, res_valid and RESULT read in the same cycle → read returns head; new nonce stored; overflow stays 0.
- In RUNNING write CTRL=3 → exactly one core_abort pulse; state IDLE; no dispatch. Then res_done → state stays IDLE.
- Assert reset mid-DISPATCH with FIFO count 2 → next cycle work_valid=0, FIFO empty, all flags 0, STATUS=0x004 (fifo_empty bit set).

Source files
------------

// File: rtl/work_slave_pkg.sv
// rtl/work_slave_pkg.sv - shared types and register map for the work slave CSR block
package work_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int N_MID  = 8;
  localparam int N_HEAD = 16;

  localparam logic [31:0] A_MID0   = 32'h00;
  localparam logic [31:0] A_HEAD0  = 32'h08;
  localparam logic [31:0] A_NONCE  = 32'h18;
  localparam logic [31:0] A_CTRL   = 32'h19;
  localparam logic [31:0] A_STATUS = 32'h1A;
  localparam logic [31:0] A_RESULT = 32'h1B;
  localparam logic [31:0] A_IRQ_EN = 32'h1C;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int ST_STATE_LSB  = 0;
  localparam int ST_EMPTY      = 2;
  localparam int ST_COUNT_LSB  = 3;
  localparam int ST_OVERFLOW   = 6;
  localparam int ST_START_ERR  = 7;
  localparam int ST_RANGE_DONE = 8;

  localparam logic [31:0] EMPTY_NONCE = 32'hFFFF_FFFF;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO buffering found nonces
// A pop frees a slot in the same cycle, so a push while full is accepted when paired with a pop.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/work_slave_csr.sv
// rtl/work_slave_csr.sv - Avalon-MM CSR slave loading mining work and draining found nonces
// Optional WORK_SLAVE_IRQ_EN adds the irq output and the IRQ_EN register.
module work_slave_csr import work_slave_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              work_valid,
  input  logic              work_ready,
  output logic [255:0]      mid_state,
  output logic [511:0]      head_data,
  output logic [31:0]       nonce_start,
  output logic              core_abort,
  input  logic              res_valid,
  input  logic [31:0]       res_nonce,
  input  logic              res_done
`ifdef WORK_SLAVE_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [31:0] addr;
  logic        ctrl_wr, start_cmd, abort_cmd, clear_cmd;
  state_e      state_q, state_d;
  logic        latch_en, start_err_set, range_done_set, abort_pulse_d;

  logic [31:0]  mid_sh_q [N_MID];
  logic [31:0]  mid_sh_d [N_MID];
  logic [31:0]  head_sh_q [N_HEAD];
  logic [31:0]  head_sh_d [N_HEAD];
  logic [31:0]  nonce_sh_q, nonce_sh_d;
  logic [255:0] mid_state_q, mid_state_d;
  logic [511:0] head_data_q, head_data_d;
  logic [31:0]  nonce_start_q, nonce_start_d;
  logic         core_abort_q;
  logic         overflow_q, overflow_d, start_err_q, start_err_d, range_done_q, range_done_d;
  logic [31:0]  avs_readdata_q, avs_readdata_d, rd_mux, status;
  logic         avs_readdatavalid_q;

  logic                          fifo_pop, fifo_full, fifo_empty, ovf_set;
  logic [31:0]                   fifo_head;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  assign addr      = 32'(avs_address);
  assign ctrl_wr   = avs_write && (addr == A_CTRL);
  assign start_cmd = ctrl_wr && avs_writedata[CTRL_START];
  assign abort_cmd = ctrl_wr && avs_writedata[CTRL_ABORT];
  assign clear_cmd = ctrl_wr && avs_writedata[CTRL_CLEAR];

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Abort overrides every other transition, including a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (abort_cmd) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (start_cmd)  state_d = ST_DISPATCH;
        ST_DISPATCH: if (work_ready) state_d = ST_RUNNING;
        ST_RUNNING:  if (res_done)   state_d = ST_DONE;
        ST_DONE:     if (start_cmd)  state_d = ST_DISPATCH;
        default:                     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    work_valid     = (state_q == ST_DISPATCH);
    latch_en       = start_cmd && !abort_cmd && (state_q == ST_IDLE || state_q == ST_DONE);
    start_err_set  = start_cmd && !abort_cmd && (state_q == ST_DISPATCH || state_q == ST_RUNNING);
    range_done_set = !abort_cmd && (state_q == ST_RUNNING) && res_done;
    abort_pulse_d  = abort_cmd && (state_q != ST_IDLE);
  end

  always_comb begin
    mid_sh_d   = mid_sh_q;
    head_sh_d  = head_sh_q;
    nonce_sh_d = nonce_sh_q;
    if (avs_write) begin
      if (addr < A_HEAD0)      mid_sh_d[3'(addr)]           = avs_writedata;
      else if (addr < A_NONCE) head_sh_d[4'(addr - A_HEAD0)] = avs_writedata;
      else if (addr == A_NONCE) nonce_sh_d                  = avs_writedata;
    end
  end

  // Core-facing copies only move at dispatch, so host writes during a run are invisible to the core.
  always_comb begin
    mid_state_d   = mid_state_q;
    head_data_d   = head_data_q;
    nonce_start_d = nonce_start_q;
    if (latch_en) begin
      for (int i = 0; i < N_MID; i++)  mid_state_d[255 - 32*i -: 32] = mid_sh_q[i];
      for (int i = 0; i < N_HEAD; i++) head_data_d[511 - 32*i -: 32] = head_sh_q[i];
      nonce_start_d = nonce_sh_q;
    end
  end

  assign fifo_pop = avs_read && (addr == A_RESULT) && !fifo_empty;
  assign ovf_set  = res_valid && fifo_full && !fifo_pop;

  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (res_valid),
    .push_data (res_nonce),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    overflow_d   = (overflow_q   && !clear_cmd) || ovf_set;
    start_err_d  = (start_err_q  && !clear_cmd) || start_err_set;
    range_done_d = (range_done_q && !clear_cmd) || range_done_set;
  end

  always_comb begin
    status                         = '0;
    status[ST_STATE_LSB +: 2]      = state_q;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_COUNT_LSB +: 3]      = 3'(fifo_count);
    status[ST_OVERFLOW]            = overflow_q;
    status[ST_START_ERR]           = start_err_q;
    status[ST_RANGE_DONE]          = range_done_q;
  end

`ifdef WORK_SLAVE_IRQ_EN
  logic [1:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  always_comb begin
    irq_en_d = (avs_write && addr == A_IRQ_EN) ? avs_writedata[1:0] : irq_en_q;
    irq_d    = (irq_en_q[0] && !fifo_empty) || (irq_en_q[1] && range_done_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  // Read mux sees pre-write register values, so a same-cycle write is not forwarded.
  always_comb begin
    rd_mux = '0;
    if (addr < A_HEAD0) begin
      rd_mux = mid_sh_q[3'(addr)];
    end else if (addr < A_NONCE) begin
      rd_mux = head_sh_q[4'(addr - A_HEAD0)];
    end else begin
      case (addr)
        A_NONCE:  rd_mux = nonce_sh_q;
        A_STATUS: rd_mux = status;
        A_RESULT: rd_mux = fifo_empty ? EMPTY_NONCE : fifo_head;
`ifdef WORK_SLAVE_IRQ_EN
        A_IRQ_EN: rd_mux = {30'b0, irq_en_q};
`endif
        default:  rd_mux = '0;
      endcase
    end
    avs_readdata_d = avs_read ? rd_mux : avs_readdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mid_sh_q            <= '{default: '0};
      head_sh_q           <= '{default: '0};
      nonce_sh_q          <= '0;
      mid_state_q         <= '0;
      head_data_q         <= '0;
      nonce_start_q       <= '0;
      core_abort_q        <= 1'b0;
      overflow_q          <= 1'b0;
      start_err_q         <= 1'b0;
      range_done_q        <= 1'b0;
      avs_readdata_q      <= '0;
      avs_readdatavalid_q <= 1'b0;
    end else begin
      mid_sh_q            <= mid_sh_d;
      head_sh_q           <= head_sh_d;
      nonce_sh_q          <= nonce_sh_d;
      mid_state_q         <= mid_state_d;
      head_data_q         <= head_data_d;
      nonce_start_q       <= nonce_start_d;
      core_abort_q        <= abort_pulse_d;
      overflow_q          <= overflow_d;
      start_err_q         <= start_err_d;
      range_done_q        <= range_done_d;
      avs_readdata_q      <= avs_readdata_d;
      avs_readdatavalid_q <= avs_read;
    end
  end

  assign mid_state         = mid_state_q;
  assign head_data         = head_data_q;
  assign nonce_start       = nonce_start_q;
  assign core_abort        = core_abort_q;
  assign avs_readdata      = avs_readdata_q;
  assign avs_readdatavalid = avs_readdatavalid_q;

endmodule

// File: tb/tb_work_slave_csr.sv
// tb/tb_work_slave_csr.sv - directed and randomized bench for work_slave_csr against a queue-based model
module tb_work_slave_csr;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   avs_address;
  logic         avs_write;
  logic [31:0]  avs_writedata;
  logic         avs_read;
  logic [31:0]  avs_readdata;
  logic         avs_readdatavalid;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] mid_state;
  logic [511:0] head_data;
  logic [31:0]  nonce_start;
  logic         core_abort;
  logic         res_valid;
  logic [31:0]  res_nonce;
  logic         res_done;
`ifdef WORK_SLAVE_IRQ_EN
  logic         irq;
`endif

  always #5 clk = ~clk;

  work_slave_csr #(.FIFO_DEPTH(DEPTH), .ADDR_W(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .work_valid        (work_valid),
    .work_ready        (work_ready),
    .mid_state         (mid_state),
    .head_data         (head_data),
    .nonce_start       (nonce_start),
    .core_abort        (core_abort),
    .res_valid         (res_valid),
    .res_nonce         (res_nonce),
    .res_done          (res_done)
`ifdef WORK_SLAVE_IRQ_EN
    ,
    .irq               (irq)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: state as an integer, result FIFO as a queue.
  logic [31:0] m_mid [8];
  logic [31:0] m_head [16];
  logic [31:0] m_nonce;
  logic [31:0] m_omid [8];
  logic [31:0] m_ohead [16];
  logic [31:0] m_once;
  logic [31:0] m_fifo [$];
  int          m_state;
  bit          m_ovf, m_serr, m_rdone, m_abort, m_rv;
  logic [31:0] m_rd;
  bit   [1:0]  m_irqen;
  bit          m_irq;

  function automatic logic [31:0] m_status();
    return {23'b0, m_rdone, m_serr, m_ovf, 3'(m_fifo.size()), m_fifo.size() == 0, 2'(m_state)};
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a < 8)  return m_mid[a];
    if (a < 24) return m_head[a - 8];
    case (a)
      24: return m_nonce;
      26: return m_status();
      27: return (m_fifo.size() != 0) ? m_fifo[0] : 32'hFFFF_FFFF;
`ifdef WORK_SLAVE_IRQ_EN
      28: return {30'b0, m_irqen};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [255:0] m_mid_out();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[255 - 32*i -: 32] = m_omid[i];
    return v;
  endfunction

  function automatic logic [511:0] m_head_out();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[511 - 32*i -: 32] = m_ohead[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_mid[i] = 0; m_omid[i] = 0; end
    for (int i = 0; i < 16; i++) begin m_head[i] = 0; m_ohead[i] = 0; end
    m_nonce = 0; m_once = 0; m_fifo.delete(); m_state = 0;
    m_ovf = 0; m_serr = 0; m_rdone = 0; m_abort = 0; m_rv = 0; m_rd = 0;
    m_irqen = 0; m_irq = 0;
  endtask

  task automatic model_update();
    int a;
    bit pop, start, abort, clr, latch;
    if (reset) begin
      model_reset();
      return;
    end
    a = int'(avs_address);
    pop = 0; latch = 0;
    m_rv = avs_read;
    if (avs_read) begin
      m_rd = m_read(a);
      pop = (a == 27) && (m_fifo.size() != 0);
    end
    m_irq = (m_irqen[0] && m_fifo.size() != 0) || (m_irqen[1] && m_rdone);
    start = avs_write && a == 25 && avs_writedata[0];
    abort = avs_write && a == 25 && avs_writedata[1];
    clr   = avs_write && a == 25 && avs_writedata[2];
    if (clr) begin m_ovf = 0; m_serr = 0; m_rdone = 0; end
    if (pop) void'(m_fifo.pop_front());
    if (res_valid) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(res_nonce);
      else m_ovf = 1;
    end
    m_abort = 0;
    if (abort) begin
      m_abort = (m_state != 0);
      m_state = 0;
    end else begin
      case (m_state)
        0: if (start) begin latch = 1; m_state = 1; end
        1: begin if (start) m_serr = 1; if (work_ready) m_state = 2; end
        2: begin if (start) m_serr = 1; if (res_done) begin m_state = 3; m_rdone = 1; end end
        default: if (start) begin latch = 1; m_state = 1; end
      endcase
    end
    if (latch) begin
      for (int i = 0; i < 8; i++) m_omid[i] = m_mid[i];
      for (int i = 0; i < 16; i++) m_ohead[i] = m_head[i];
      m_once = m_nonce;
    end
    if (avs_write) begin
      if (a < 8) m_mid[a] = avs_writedata;
      else if (a < 24) m_head[a - 8] = avs_writedata;
      else if (a == 24) m_nonce = avs_writedata;
      else if (a == 28) m_irqen = avs_writedata[1:0];
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_eq("work_valid", work_valid, m_state == 1);
    check_eq("core_abort", core_abort, m_abort);
    check_eq("readdatavalid", avs_readdatavalid, m_rv);
    if (m_rv) check_eq("readdata", avs_readdata, m_rd);
    check_eq("mid_state", mid_state, m_mid_out());
    check_eq("head_data", head_data, m_head_out());
    check_eq("nonce_start", nonce_start, m_once);
`ifdef WORK_SLAVE_IRQ_EN
    check_eq("irq", irq, m_irq);
`endif
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs_write = 1; avs_address = a; avs_writedata = d;
    step();
    avs_write = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    avs_read = 1; avs_address = a;
    step();
    avs_read = 0;
    check_eq("rd_latency", avs_readdatavalid, 1'b1);
    v = avs_readdata;
  endtask

  logic [31:0] v;
  int          cnt;

  initial begin
    reset = 1; avs_address = 0; avs_write = 0; avs_writedata = 0; avs_read = 0;
    work_ready = 0; res_valid = 0; res_nonce = 0; res_done = 0;
    model_reset();
    step(); step();
    reset = 0;
    check_eq("rst_readdata", avs_readdata, 32'h0);
    check_eq("rst_work_valid", work_valid, 1'b0);
    rd(5'h1A, v);
    check_eq("rst_status", v, 32'h4);

    // Load work and dispatch with a slow core.
    wr(5'h00, 32'h6A09E667); wr(5'h17, 32'h280); wr(5'h18, 32'h10); wr(5'h19, 32'h1);
    cnt = work_valid ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      work_ready = (i == 3);
      step();
      if (work_valid) cnt++;
    end
    work_ready = 0;
    check_eq("dispatch_cycles", cnt, 4);
    check_eq("mid0_latched", mid_state[255:224], 32'h6A09E667);
    check_eq("head15_latched", head_data[31:0], 32'h280);
    check_eq("nonce_latched", nonce_start, 32'h10);
    rd(5'h1A, v);
    check_eq("running_state", v[1:0], 2'd2);

    // Shadow rewrite and start while running.
    wr(5'h00, 32'h0); wr(5'h19, 32'h1);
    check_eq("mid0_held", mid_state[255:224], 32'h6A09E667);
    rd(5'h1A, v);
    check_eq("start_err", v[7], 1'b1);
    check_eq("still_running", v[1:0], 2'd2);

    // Overflow and drain.
    for (int i = 1; i <= 5; i++) begin
      res_valid = 1; res_nonce = i; step();
    end
    res_valid = 0;
    rd(5'h1A, v);
    check_eq("overflow_set", v[6], 1'b1);
    check_eq("count_full", v[5:3], 3'd4);
    for (int i = 1; i <= 4; i++) begin
      rd(5'h1B, v);
      check_eq("drain", v, i);
    end
    rd(5'h1B, v);
    check_eq("drain_empty", v, 32'hFFFF_FFFF);
    wr(5'h19, 32'h4);
    rd(5'h1A, v);
    check_eq("flags_cleared", v[8:6], 3'd0);

    // Pop and push together while full.
    for (int i = 0; i < 4; i++) begin
      res_valid = 1; res_nonce = 32'h11 + i; step();
    end
    res_valid = 1; res_nonce = 32'h15;
    rd(5'h1B, v);
    res_valid = 0;
    check_eq("full_pop_head", v, 32'h11);
    rd(5'h1A, v);
    check_eq("full_pop_no_ovf", v[6], 1'b0);
    check_eq("full_pop_count", v[5:3], 3'd4);
    for (int i = 0; i < 4; i++) begin
      rd(5'h1B, v);
      check_eq("drain2", v, 32'h12 + i);
    end

    // Start+abort while running: abort wins.
    wr(5'h19, 32'h3);
    cnt = core_abort ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (core_abort) cnt++;
    end
    check_eq("abort_pulses", cnt, 1);
    rd(5'h1A, v);
    check_eq("abort_idle", v[1:0], 2'd0);
    res_done = 1; step(); res_done = 0;
    rd(5'h1A, v);
    check_eq("done_in_idle", v[1:0], 2'd0);
    check_eq("no_range_done", v[8], 1'b0);

    // Reset in the middle of a dispatch.
    wr(5'h19, 32'h1); wr(5'h19, 32'h1);
    res_valid = 1; res_nonce = 32'hA; step(); res_nonce = 32'hB; step(); res_valid = 0;
    rd(5'h1A, v);
    check_eq("pre_reset_status", v[8:0], 9'h091);
    reset = 1; step(); reset = 0;
    check_eq("post_reset_work_valid", work_valid, 1'b0);
    rd(5'h1A, v);
    check_eq("post_reset_status", v, 32'h4);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      avs_address = ($urandom_range(0, 1) == 0) ? 5'(24 + $urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      avs_write  = ($urandom_range(0, 3) == 0);
      avs_writedata = $urandom;
      if (avs_address == 5'h19)
        avs_writedata = {29'b0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1))};
      avs_read   = ($urandom_range(0, 2) == 0);
      work_ready = ($urandom_range(0, 1) == 0);
      res_valid  = ($urandom_range(0, 2) == 0);
      res_nonce  = $urandom;
      res_done   = ($urandom_range(0, 7) == 0);
      step();
    end
    reset = 0; avs_write = 0; avs_read = 0; res_valid = 0; res_done = 0; work_ready = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
